// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core: opcodes, memory access sizes,
// control bundle widths and the bit positions of fields inside the bundles.
package cpu_pkg;

  localparam logic [5:0] Rtype = 6'b000000;
  localparam logic [5:0] addi  = 6'b001000;
  localparam logic [5:0] andi  = 6'b001100;
  localparam logic [5:0] ori   = 6'b001101;
  localparam logic [5:0] slti  = 6'b001010;
  localparam logic [5:0] beq   = 6'b000100;
  localparam logic [5:0] bne   = 6'b000101;
  localparam logic [5:0] lw    = 6'b100011;
  localparam logic [5:0] sw    = 6'b101011;
  localparam logic [5:0] lb    = 6'b100000;
  localparam logic [5:0] sb    = 6'b101000;
  localparam logic [5:0] j     = 6'b000010;
  localparam logic [5:0] jal   = 6'b000011;

  localparam logic [1:0] WordWork = 2'b01;
  localparam logic [1:0] ByteWork = 2'b10;

  localparam int WB_W = 2;
  localparam int M_W  = 4;
  localparam int EX_W = 8;

  // M = {MemRead[1:0], MemWrite[1:0]}, EX = {ALUSrc, ALUOp[5:0], RegDst}
  localparam int M_RD_HI   = 3;
  localparam int M_RD_LO   = 2;
  localparam int M_WR_HI   = 1;
  localparam int M_WR_LO   = 0;
  localparam int EX_ALUSRC = 7;
  localparam int EX_REGDST = 0;

  function automatic logic mem_reads(input logic [M_W-1:0] m);
    return m[M_RD_HI:M_RD_LO] != 2'b00;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection: the load in EX writes a register that the
// instruction in ID reads, so the ID instruction must wait one cycle.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              haz
);

  // $0 is hard-wired to zero, so a load targeting it never produces a value to wait for
  assign haz = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid &
               ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch/jump flush,
// global hold and a saturating count of inserted bubbles.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WB_W-1:0]   id_wb_i,
  input  logic [M_W-1:0]    id_m_i,
  input  logic [EX_W-1:0]   id_ex_i,
  input  logic [DATA_W-1:0] id_rd1_i,
  input  logic [DATA_W-1:0] id_rd2_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [DATA_W-1:0] id_pc4_i,
  input  logic              id_valid_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic [WB_W-1:0]   ex_wb_o,
  output logic [M_W-1:0]    ex_m_o,
  output logic [EX_W-1:0]   ex_ex_o,
  output logic [DATA_W-1:0] ex_rd1_o,
  output logic [DATA_W-1:0] ex_rd2_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [DATA_W-1:0] ex_pc4_o,
  output logic [REG_AW-1:0] ex_rs_o,
  output logic [REG_AW-1:0] ex_rt_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              ex_valid_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic haz;
  logic ex_mem_read;

  assign ex_mem_read = mem_reads(ex_m_o);

  load_use_detect #(.REG_AW(REG_AW)) u_detect (
    .ex_valid    (ex_valid_o),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt_o),
    .id_valid    (id_valid_i),
    .id_rs       (id_rs_i),
    .id_rt       (id_rt_i),
    .haz         (haz)
  );

  // Stall protocol: stall_o freezes PC and IF/ID in the same cycle it is high;
  // hold_i freezes everything here, and a flush wins over a stall because the
  // ID instruction is wrong-path and is dropped instead of waiting.
  assign stall_o = haz & ~flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_wb_o      <= '0;
      ex_m_o       <= '0;
      ex_ex_o      <= '0;
      ex_rd1_o     <= '0;
      ex_rd2_o     <= '0;
      ex_imm_o     <= '0;
      ex_pc4_o     <= '0;
      ex_rs_o      <= '0;
      ex_rt_o      <= '0;
      ex_rd_o      <= '0;
      ex_valid_o   <= 1'b0;
      bubble_cnt_o <= '0;
    end else if (!hold_i) begin
      if (flush_i || haz) begin
        ex_wb_o    <= '0;
        ex_m_o     <= '0;
        ex_ex_o    <= '0;
        ex_rd1_o   <= '0;
        ex_rd2_o   <= '0;
        ex_imm_o   <= '0;
        ex_pc4_o   <= '0;
        ex_rs_o    <= '0;
        ex_rt_o    <= '0;
        ex_rd_o    <= '0;
        ex_valid_o <= 1'b0;
        if (!flush_i && (bubble_cnt_o != CNT_MAX)) begin
          bubble_cnt_o <= bubble_cnt_o + CNT_ONE;
        end
      end else begin
        // an empty IF/ID slot must not carry write/memory side effects into EX
        ex_wb_o    <= id_valid_i ? id_wb_i : '0;
        ex_m_o     <= id_valid_i ? id_m_i  : '0;
        ex_ex_o    <= id_valid_i ? id_ex_i : '0;
        ex_rd1_o   <= id_rd1_i;
        ex_rd2_o   <= id_rd2_i;
        ex_imm_o   <= id_imm_i;
        ex_pc4_o   <= id_pc4_i;
        ex_rs_o    <= id_rs_i;
        ex_rt_o    <= id_rt_i;
        ex_rd_o    <= id_rd_i;
        ex_valid_o <= id_valid_i;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  id_wb_i;
  logic [3:0]  id_m_i;
  logic [7:0]  id_ex_i;
  logic [31:0] id_rd1_i, id_rd2_i, id_imm_i, id_pc4_i;
  logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
  logic        id_valid_i, flush_i, hold_i;

  logic [1:0]  ex_wb_o;
  logic [3:0]  ex_m_o;
  logic [7:0]  ex_ex_o;
  logic [31:0] ex_rd1_o, ex_rd2_o, ex_imm_o, ex_pc4_o;
  logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;
  logic        ex_valid_o, stall_o;
  logic [15:0] bubble_cnt_o;

  logic [1:0]  s_wb;
  logic [3:0]  s_m;
  logic [7:0]  s_ex;
  logic [31:0] s_rd1, s_rd2, s_imm, s_pc4;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic        s_valid, s_stall;
  logic [1:0]  s_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .id_wb_i(id_wb_i), .id_m_i(id_m_i), .id_ex_i(id_ex_i),
    .id_rd1_i(id_rd1_i), .id_rd2_i(id_rd2_i), .id_imm_i(id_imm_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .id_pc4_i(id_pc4_i), .id_valid_i(id_valid_i), .flush_i(flush_i), .hold_i(hold_i),
    .ex_wb_o(ex_wb_o), .ex_m_o(ex_m_o), .ex_ex_o(ex_ex_o),
    .ex_rd1_o(ex_rd1_o), .ex_rd2_o(ex_rd2_o), .ex_imm_o(ex_imm_o), .ex_pc4_o(ex_pc4_o),
    .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
    .ex_valid_o(ex_valid_o), .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
  );

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .id_wb_i(id_wb_i), .id_m_i(id_m_i), .id_ex_i(id_ex_i),
    .id_rd1_i(id_rd1_i), .id_rd2_i(id_rd2_i), .id_imm_i(id_imm_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .id_pc4_i(id_pc4_i), .id_valid_i(id_valid_i), .flush_i(flush_i), .hold_i(hold_i),
    .ex_wb_o(s_wb), .ex_m_o(s_m), .ex_ex_o(s_ex),
    .ex_rd1_o(s_rd1), .ex_rd2_o(s_rd2), .ex_imm_o(s_imm), .ex_pc4_o(s_pc4),
    .ex_rs_o(s_rs), .ex_rt_o(s_rt), .ex_rd_o(s_rd),
    .ex_valid_o(s_valid), .stall_o(s_stall), .bubble_cnt_o(s_cnt)
  );

  // ---------------- behavioural model + scoreboard ----------------
  logic [1:0]  m_wb;
  logic [3:0]  m_m;
  logic [7:0]  m_ex;
  logic [31:0] m_rd1, m_rd2, m_imm, m_pc4;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic        m_valid;
  int          bub_total;
  logic [175:0] exp_q[$];

  function automatic void model_clear_ex();
    m_wb = '0; m_m = '0; m_ex = '0;
    m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_pc4 = '0;
    m_rs = '0; m_rt = '0; m_rd = '0; m_valid = 1'b0;
  endfunction

  // EX holds a live load of a nonzero register and the ID instruction reads it
  function automatic bit model_load_use();
    bit ex_is_load;
    bit reads_it;
    ex_is_load = m_valid && (m_m[3:2] != 2'b00) && (m_rt != 5'd0);
    reads_it   = id_valid_i && ((id_rs_i == m_rt) || (id_rt_i == m_rt));
    return ex_is_load && reads_it;
  endfunction

  function automatic logic [175:0] model_vec();
    logic [15:0] c16;
    logic [1:0]  c2;
    c16 = (bub_total > 65535) ? 16'hFFFF : 16'(bub_total);
    c2  = (bub_total > 3) ? 2'd3 : 2'(bub_total);
    return {m_wb, m_m, m_ex, m_rd1, m_rd2, m_imm, m_pc4, m_rs, m_rt, m_rd, m_valid, c16, c2};
  endfunction

  initial begin
    model_clear_ex();
    bub_total = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_clear_ex();
        bub_total = 0;
        exp_q.delete();
      end else begin
        if (!hold_i) begin
          if (flush_i) begin
            model_clear_ex();
          end else if (model_load_use()) begin
            model_clear_ex();
            bub_total++;
          end else begin
            m_wb  = id_valid_i ? id_wb_i : 2'b00;
            m_m   = id_valid_i ? id_m_i  : 4'b0000;
            m_ex  = id_valid_i ? id_ex_i : 8'h00;
            m_rd1 = id_rd1_i; m_rd2 = id_rd2_i; m_imm = id_imm_i; m_pc4 = id_pc4_i;
            m_rs  = id_rs_i;  m_rt  = id_rt_i;  m_rd  = id_rd_i;
            m_valid = id_valid_i;
          end
        end
        exp_q.push_back(model_vec());
      end
    end
  end

  // compare process: registered outputs and stall on every falling edge
  initial begin
    logic [175:0] exp_v, act_v;
    logic [157:0] sat_v;
    bit           exp_stall;
    forever begin
      @(negedge clk);
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : model_vec();
      act_v = {ex_wb_o, ex_m_o, ex_ex_o, ex_rd1_o, ex_rd2_o, ex_imm_o, ex_pc4_o,
               ex_rs_o, ex_rt_o, ex_rd_o, ex_valid_o, bubble_cnt_o, s_cnt};
      sat_v = {s_wb, s_m, s_ex, s_rd1, s_rd2, s_imm, s_pc4, s_rs, s_rt, s_rd, s_valid};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL ex_regs @%0t: got %h expected %h", $time, act_v, exp_v);
      end
      n_cmp++;
      if (sat_v !== exp_v[175:18]) begin
        n_bad++;
        $display("FAIL sat_regs @%0t: got %h expected %h", $time, sat_v, exp_v[175:18]);
      end
      exp_stall = model_load_use() && !flush_i;
      n_cmp++;
      if (stall_o !== exp_stall || s_stall !== exp_stall) begin
        n_bad++;
        $display("FAIL stall @%0t: got %b/%b expected %b", $time, stall_o, s_stall, exp_stall);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input logic [1:0] wb, input logic [3:0] m, input logic [7:0] ex,
                             input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [31:0] rd1, input logic [31:0] imm);
    id_wb_i = wb; id_m_i = m; id_ex_i = ex;
    id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
    id_rd1_i = rd1; id_imm_i = imm;
    id_rd2_i = $urandom; id_pc4_i = $urandom;
    id_valid_i = 1'b1; flush_i = 1'b0; hold_i = 1'b0;
  endtask

  task automatic rand_inputs();
    id_valid_i = ($urandom_range(0, 9) != 0);
    id_wb_i = 2'($urandom);
    case ($urandom_range(0, 4))
      0: id_m_i = 4'b0100;
      1: id_m_i = 4'b1000;
      2: id_m_i = 4'b0001;
      3: id_m_i = 4'b0010;
      default: id_m_i = 4'b0000;
    endcase
    id_ex_i = 8'($urandom);
    id_rd1_i = $urandom; id_rd2_i = $urandom; id_imm_i = $urandom; id_pc4_i = $urandom;
    id_rs_i = 5'($urandom_range(0, 3));
    id_rt_i = 5'($urandom_range(0, 3));
    id_rd_i = 5'($urandom_range(0, 31));
    flush_i = ($urandom_range(0, 9) == 0);
    hold_i  = ($urandom_range(0, 9) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset with nonzero inputs, observed before any clock edge
    drive_instr(2'b11, 4'b0100, 8'h80, 5'd9, 5'd8, 5'd7, 32'h1234, 32'h5678);
    #3;
    chk("rst_valid", ex_valid_o, 0);
    chk("rst_m", ex_m_o, 0);
    chk("rst_wb", ex_wb_o, 0);
    chk("rst_rd1", ex_rd1_o, 0);
    chk("rst_cnt", bubble_cnt_o, 0);
    chk("rst_stall", stall_o, 0);
    tick(); tick();
    rst_n = 1'b1;

    // addi pass-through
    drive_instr(2'b01, 4'b0000, 8'b1_001000_0, 5'd1, 5'd2, 5'd0, 32'd5, 32'd7);
    tick();
    chk("pass_ex", ex_ex_o, 8'h90);
    chk("pass_rd1", ex_rd1_o, 5);
    chk("pass_imm", ex_imm_o, 7);
    chk("pass_valid", ex_valid_o, 1);
    chk("pass_wb", ex_wb_o, 2'b01);

    // load-use: one bubble, then the dependent add enters EX
    drive_instr(2'b11, 4'b0100, 8'h80, 5'd9, 5'd8, 5'd0, 32'd1, 32'd4);
    tick();
    chk("lu_ex_m", ex_m_o, 4'b0100);
    drive_instr(2'b01, 4'b0000, 8'h01, 5'd8, 5'd10, 5'd11, 32'd2, 32'd0);
    #1 chk("lu_stall", stall_o, 1);
    tick();
    chk("lu_bub_valid", ex_valid_o, 0);
    chk("lu_bub_m", ex_m_o, 0);
    chk("lu_bub_wb", ex_wb_o, 0);
    chk("lu_cnt", bubble_cnt_o, 1);
    chk("lu_stall_drop", stall_o, 0);
    tick();
    chk("lu_add_valid", ex_valid_o, 1);
    chk("lu_add_rs", ex_rs_o, 8);
    chk("lu_add_ex", ex_ex_o, 8'h01);

    // flush over hazard
    drive_instr(2'b11, 4'b0100, 8'h80, 5'd9, 5'd8, 5'd0, 32'd1, 32'd4);
    tick();
    drive_instr(2'b01, 4'b0000, 8'h01, 5'd8, 5'd10, 5'd11, 32'd2, 32'd0);
    flush_i = 1'b1;
    #1 chk("fl_stall", stall_o, 0);
    tick();
    chk("fl_valid", ex_valid_o, 0);
    chk("fl_m", ex_m_o, 0);
    chk("fl_cnt", bubble_cnt_o, 1);
    flush_i = 1'b0;

    // hold freezes EX even with flush and changing inputs
    drive_instr(2'b01, 4'b0000, 8'h90, 5'd1, 5'd2, 5'd0, 32'hDEAD_0001, 32'd3);
    tick();
    chk("hold_pre", ex_rd1_o, 32'hDEAD_0001);
    hold_i = 1'b1;
    flush_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_rd1_i = $urandom; id_rs_i = 5'($urandom); id_wb_i = 2'($urandom);
      tick();
      chk("hold_rd1", ex_rd1_o, 32'hDEAD_0001);
      chk("hold_valid", ex_valid_o, 1);
    end
    hold_i = 1'b0;
    tick();
    chk("hold_rel_valid", ex_valid_o, 0);
    chk("hold_rel_rd1", ex_rd1_o, 0);
    flush_i = 1'b0;

    // lw to $0 then read of $0
    drive_instr(2'b11, 4'b0100, 8'h80, 5'd9, 5'd0, 5'd0, 32'd1, 32'd4);
    tick();
    drive_instr(2'b01, 4'b0000, 8'h01, 5'd0, 5'd0, 5'd11, 32'd2, 32'd0);
    #1 chk("r0_stall", stall_o, 0);
    tick();
    chk("r0_valid", ex_valid_o, 1);

    // store then use of the same rt
    drive_instr(2'b00, 4'b0001, 8'h80, 5'd9, 5'd8, 5'd0, 32'd1, 32'd4);
    tick();
    drive_instr(2'b01, 4'b0000, 8'h01, 5'd8, 5'd8, 5'd11, 32'd2, 32'd0);
    #1 chk("sw_stall", stall_o, 0);
    tick();
    chk("sw_valid", ex_valid_o, 1);
    chk("sw_cnt", bubble_cnt_o, 1);

    // reset asserted mid-stall drops stall_o immediately
    drive_instr(2'b11, 4'b0100, 8'h80, 5'd9, 5'd5, 5'd0, 32'd1, 32'd4);
    tick();
    drive_instr(2'b01, 4'b0000, 8'h01, 5'd5, 5'd5, 5'd11, 32'd2, 32'd0);
    #1 chk("mr_stall", stall_o, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_stall_low", stall_o, 0);
    chk("mr_m", ex_m_o, 0);
    chk("mr_cnt", bubble_cnt_o, 0);
    tick();
    rst_n = 1'b1;

    // five bubbles, both sources matching: 16-bit counter 5, 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      drive_instr(2'b11, 4'b1000, 8'h80, 5'd9, 5'd3, 5'd0, 32'd1, 32'd4);
      tick();
      drive_instr(2'b01, 4'b0000, 8'h01, 5'd3, 5'd3, 5'd12, 32'd2, 32'd0);
      tick();
      tick();
    end
    chk("sat_cnt16", bubble_cnt_o, 5);
    chk("sat_cnt2", s_cnt, 3);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      tick();
    end
    hold_i = 1'b0;
    flush_i = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
